// File: rtl/incubator_ctrl_if.sv
// incubator_ctrl_if: sensor, fan-feedback and actuator/status signals of the incubator controller
interface incubator_ctrl_if;
    logic signed [7:0] T;
    logic              T_valid;
    logic [3:0]        CRS;
    logic              Cooler;
    logic              Heater;
    logic [1:0]        state;
    logic              alarm;
    logic              stall;
    modport master (output T, T_valid, CRS, input Cooler, Heater, state, alarm, stall);
    modport slave  (input T, T_valid, CRS, output Cooler, Heater, state, alarm, stall);
endinterface

// File: rtl/incubator_ctrl.sv
// incubator_ctrl: hysteretic heat/cool thermostat with dwell limit, overtemperature alarm and fan-stall detect
module incubator_ctrl #(
    parameter int T_LOW     = 15,
    parameter int T_HIGH    = 35,
    parameter int HYST      = 3,
    parameter int T_CRIT    = 50,
    parameter int CRIT_CNT  = 3,
    parameter int MIN_DWELL = 8,
    parameter int STALL_CYC = 16
) (
    input logic             clk,
    input logic             rst,
    incubator_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HEAT, COOL, ALARM} state_t;
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int CW = $clog2(CRIT_CNT + 1);
    localparam int SW = $clog2(STALL_CYC + 1);
    localparam logic signed [7:0] TLO  = 8'(T_LOW);
    localparam logic signed [7:0] THI  = 8'(T_HIGH);
    localparam logic signed [7:0] TCR  = 8'(T_CRIT);
    localparam logic signed [8:0] LO_H = 9'(T_LOW) + 9'(HYST);
    localparam logic signed [8:0] HI_L = 9'(T_HIGH) - 9'(HYST);
    state_t            state_q, state_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [CW-1:0]     ovt_q, ovt_d;
    logic [SW-1:0]     stl_q, stl_d;
    logic              heater_q, cooler_q, alarm_q, stall_q;
    logic signed [7:0] t;
    logic signed [8:0] t9;
    logic              dwell_done;
    assign t          = bus.T;
    assign t9         = {t[7], t};
    assign dwell_done = dwell_q == DW'(MIN_DWELL);
    // Next state, dwell/overtemperature/stall counters; alarm entry overrides all other moves
    always_comb begin
        ovt_d   = ovt_q;
        state_d = state_q;
        if (bus.T_valid) begin
            ovt_d = (t > TCR) ? ((ovt_q == CW'(CRIT_CNT)) ? ovt_q : ovt_q + 1'b1) : '0;
            if (ovt_d == CW'(CRIT_CNT)) state_d = ALARM;
            else case (state_q)
                IDLE:  if (dwell_done) state_d = (t < TLO) ? HEAT : (t > THI) ? COOL : IDLE;
                HEAT:  if (dwell_done && t9 >= LO_H) state_d = IDLE;
                COOL:  if (dwell_done && t9 <= HI_L) state_d = IDLE;
                ALARM: if (t <= THI) state_d = COOL;
            endcase
        end
        dwell_d = (state_d != state_q) ? '0 : dwell_done ? dwell_q : dwell_q + 1'b1;
        stl_d   = (cooler_q && bus.CRS == '0) ? ((stl_q == SW'(STALL_CYC)) ? stl_q : stl_q + 1'b1) : '0;
    end
    // State, counters and actuator outputs all update on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dwell_q  <= '0;
            ovt_q    <= '0;
            stl_q    <= '0;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
            alarm_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            ovt_q    <= ovt_d;
            stl_q    <= stl_d;
            heater_q <= state_d == HEAT;
            cooler_q <= state_d == COOL || state_d == ALARM;
            alarm_q  <= state_d == ALARM;
            stall_q  <= stall_q | (stl_d == SW'(STALL_CYC));
        end
    end
    assign bus.state  = state_q;
    assign bus.Heater = heater_q;
    assign bus.Cooler = cooler_q;
    assign bus.alarm  = alarm_q;
    assign bus.stall  = stall_q;
endmodule

// File: tb/tb_incubator_ctrl.sv
// tb_incubator_ctrl: directed scenarios plus randomized run against a behavioural thermostat model
module tb_incubator_ctrl;
    localparam int T_LOW = 15, T_HIGH = 35, HYST = 3, T_CRIT = 50;
    localparam int CRIT_CNT = 3, MIN_DWELL = 8, STALL_CYC = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0, checks = 0;
    int ms, since, hot, run;
    bit mstall;
    incubator_ctrl_if ifc();
    incubator_ctrl #(.T_LOW(T_LOW), .T_HIGH(T_HIGH), .HYST(HYST), .T_CRIT(T_CRIT),
                     .CRIT_CNT(CRIT_CNT), .MIN_DWELL(MIN_DWELL), .STALL_CYC(STALL_CYC))
        dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", {30'd0, ifc.state}, ms);
        chk("heater", {31'd0, ifc.Heater}, int'(ms == 1));
        chk("cooler", {31'd0, ifc.Cooler}, int'(ms >= 2));
        chk("alarm", {31'd0, ifc.alarm}, int'(ms == 3));
        chk("stall", {31'd0, ifc.stall}, int'(mstall));
        chk("exclusive", {31'd0, ifc.Heater & ifc.Cooler}, 0);
    endtask

    task automatic model_reset();
        ms = 0; since = 0; hot = 0; run = 0; mstall = 0;
    endtask

    // Model: states 0..3, "since" = clocks since last state change, "hot" = consecutive hot samples
    task automatic model_step(input int t, input bit v, input int crs);
        int hn, ns;
        bit cool;
        cool = ms >= 2;
        hn = v ? ((t > T_CRIT) ? hot + 1 : 0) : hot;
        ns = ms;
        if (v) begin
            if (hn >= CRIT_CNT) ns = 3;
            else if (ms == 3) ns = (t <= T_HIGH) ? 2 : 3;
            else if (since >= MIN_DWELL) begin
                if (ms == 0) ns = (t < T_LOW) ? 1 : (t > T_HIGH) ? 2 : 0;
                else if (ms == 1 && t >= T_LOW + HYST) ns = 0;
                else if (ms == 2 && t <= T_HIGH - HYST) ns = 0;
            end
        end
        since = (ns != ms) ? 0 : since + 1;
        hot = hn;
        run = (cool && crs == 0) ? run + 1 : 0;
        if (run >= STALL_CYC) mstall = 1;
        ms = ns;
    endtask

    task automatic cyc(input int t, input bit v, input int crs);
        ifc.T = 8'(t);
        ifc.T_valid = v;
        ifc.CRS = 4'(crs);
        model_step(t, v, crs);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic areset();
        ifc.T_valid = 1'b0;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        ifc.T = '0; ifc.T_valid = 1'b0; ifc.CRS = 4'd4;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(10, 1, 4);
        chk("no_heat_before_dwell", {30'd0, ifc.state}, 0);
        cyc(10, 1, 4);
        chk("heat_entry", {31'd0, ifc.Heater}, 1);
        for (int i = 0; i < 9; i++) cyc(18, 1, 4);
        chk("heat_exit", {30'd0, ifc.state}, 0);
        for (int i = 0; i < 9; i++) cyc(40, 1, 4);
        chk("cool_entry", {31'd0, ifc.Cooler}, 1);
        for (int i = 0; i < 3; i++) cyc(33, 1, 4);
        chk("cool_hold_33", {30'd0, ifc.state}, 2);
        for (int i = 0; i < 5; i++) cyc(32, 1, 4);
        chk("cool_hold_dwell", {30'd0, ifc.state}, 2);
        cyc(32, 1, 4);
        chk("cool_exit", {30'd0, ifc.state}, 0);
        for (int i = 0; i < 9; i++) cyc(10, 1, 4);
        chk("heat_again", {30'd0, ifc.state}, 1);
        cyc(51, 1, 4); cyc(51, 1, 4); cyc(49, 1, 4); cyc(51, 1, 4); cyc(51, 1, 4);
        chk("crit_count_reset", {30'd0, ifc.state}, 1);
        cyc(51, 1, 4);
        chk("alarm_state", {30'd0, ifc.state}, 3);
        chk("alarm_flag", {31'd0, ifc.alarm}, 1);
        chk("alarm_heater", {31'd0, ifc.Heater}, 0);
        cyc(36, 1, 4);
        chk("alarm_hold_36", {30'd0, ifc.state}, 3);
        cyc(35, 1, 4);
        chk("alarm_to_cool", {30'd0, ifc.state}, 2);
        chk("alarm_cleared", {31'd0, ifc.alarm}, 0);
        for (int i = 0; i < 15; i++) cyc(35, 0, 0);
        chk("stall_not_yet", {31'd0, ifc.stall}, 0);
        cyc(35, 0, 0);
        chk("stall_set", {31'd0, ifc.stall}, 1);
        chk("stall_state_kept", {30'd0, ifc.state}, 2);
        for (int i = 0; i < 4; i++) cyc(35, 0, 4);
        chk("stall_sticky", {31'd0, ifc.stall}, 1);
        areset();
        chk("stall_cleared_by_rst", {31'd0, ifc.stall}, 0);
        for (int i = 0; i < 3; i++) cyc(60, 1, 4);
        chk("alarm_ignores_dwell", {30'd0, ifc.state}, 3);
        areset();
        chk("rst_alarm_off", {31'd0, ifc.alarm}, 0);
        chk("rst_cooler_off", {31'd0, ifc.Cooler}, 0);
        for (int i = 0; i < 1500; i++) begin
            int t, r;
            r = int'($urandom_range(0, 3));
            t = (r == 0) ? int'($urandom_range(0, 30)) :
                (r == 1) ? int'($urandom_range(28, 42)) :
                (r == 2) ? int'($urandom_range(45, 60)) : int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 199) == 0) areset();
            else cyc(t, bit'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(0, 15)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/incubator_ctrl.md
INCUBATOR_CTRL -- requirements
Module: incubator_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter T_LOW, default 15, SHALL be the heat-on threshold (signed deg C).
REQ-003 Parameter T_HIGH, default 35, SHALL be the cool-on threshold (signed deg C).
REQ-004 Parameter HYST, default 3, SHALL be the hysteresis band (deg C).
REQ-005 Parameter T_CRIT, default 50, SHALL be the overtemperature threshold (signed deg C).
REQ-006 Parameter CRIT_CNT, default 3, SHALL be the number of consecutive valid samples above T_CRIT that triggers alarm.
REQ-007 Parameter MIN_DWELL, default 8, SHALL be the minimum number of clocks between actuator changes.
REQ-008 Parameter STALL_CYC, default 16, SHALL be the number of consecutive clocks with CRS==0 that flags a fan stall.
REQ-009 Port clk, input, 1 bit: rising-edge clock.
REQ-010 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-011 Port T, input, 8 bits, signed: temperature sample.
REQ-012 Port T_valid, input, 1 bit: single-cycle strobe qualifying T.
REQ-013 Port CRS, input, 4 bits: fan speed feedback from the fan controller.
REQ-014 Port Cooler, output, 1 bit, registered: cooler/fan-controller enable.
REQ-015 Port Heater, output, 1 bit, registered: heater enable.
REQ-016 Port state, output, 2 bits: current state, IDLE=0, HEAT=1, COOL=2, ALARM=3.
REQ-017 Port alarm, output, 1 bit: overtemperature indication.
REQ-018 Port stall, output, 1 bit: sticky fan-stall flag.

Function
REQ-019 All comparisons of T against the thresholds SHALL be signed 8-bit; T_LOW+HYST and T_HIGH-HYST SHALL be computed at 9-bit width.
REQ-020 State transitions SHALL be evaluated only in cycles where T_valid=1; in all other cycles the state SHALL hold.
REQ-021 The dwell counter SHALL clear to 0 on every state change, increment each clock otherwise, and saturate at MIN_DWELL; "dwell done" means dwell counter == MIN_DWELL.
REQ-022 IDLE SHALL go to HEAT when T < T_LOW and dwell is done, and to COOL when T > T_HIGH and dwell is done.
REQ-023 HEAT SHALL go to IDLE when T >= T_LOW+HYST and dwell is done.
REQ-024 COOL SHALL go to IDLE when T <= T_HIGH-HYST and dwell is done.
REQ-025 The overtemperature counter SHALL increment (saturating at CRIT_CNT) on each valid sample with T > T_CRIT, SHALL clear on each valid sample with T <= T_CRIT, and SHALL hold on non-valid cycles.
REQ-026 When the overtemperature counter reaches CRIT_CNT, the block SHALL enter ALARM from any state on that same valid sample, regardless of dwell; this SHALL take priority over all other transitions.
REQ-027 ALARM SHALL go to COOL on a valid sample with T <= T_HIGH, ignoring dwell.
REQ-028 Outputs SHALL be registered and updated in the same clock edge as the state register: IDLE gives Heater=0, Cooler=0; HEAT gives Heater=1, Cooler=0; COOL gives Heater=0, Cooler=1; ALARM gives Heater=0, Cooler=1, alarm=1.
REQ-029 Heater and Cooler SHALL never be 1 in the same cycle.
REQ-030 The stall counter SHALL increment (saturating) on each clock with Cooler=1 and CRS==0, and SHALL clear otherwise.
REQ-031 When the stall counter reaches STALL_CYC, stall SHALL be set to 1 and SHALL remain 1 until reset.
REQ-032 A setting of stall SHALL NOT change the state.

Reset
REQ-033 While rst=1, the block SHALL immediately force: state=IDLE, Heater=0, Cooler=0, alarm=0, stall=0, all counters=0.
REQ-034 Reset asserted mid-operation, including in ALARM, SHALL abort the operation with no residual state.
REQ-035 After reset release, the first transition out of IDLE SHALL require dwell done, i.e. MIN_DWELL clocks.

Verification
REQ-036 Scenario: after reset, T=10 valid every clock -> HEAT entered on the first valid sample after 8 clocks, with Heater=1; then T=18 -> IDLE once dwell done.
REQ-037 Scenario: in IDLE with dwell done, T=40 valid -> COOL with Cooler=1; then T=33 before 8 clocks -> stays COOL; T=32 after dwell -> IDLE.
REQ-038 Scenario: T=51 on 3 consecutive valid samples from HEAT -> ALARM on the 3rd sample, with Heater=0, Cooler=1, alarm=1; a T=49 sample between them resets the count.
REQ-039 Scenario: in ALARM, T=35 valid -> COOL with alarm=0; T=36 -> stays ALARM.
REQ-040 Scenario: in COOL with CRS=0 for 16 clocks -> stall=1 and state unchanged; CRS=4 afterwards -> stall stays 1 until rst.
REQ-041 Scenario: rst pulsed mid-ALARM -> all outputs 0 asynchronously, before the next clk edge.
